// File: rtl/datapath_unit_pkg.sv
// datapath_unit shared definitions: widths, instruction field offsets,
// opcodes, FSM states and the LFSR step function.
package datapath_unit_pkg;

   localparam int OPERAND_WIDTH_DEF = 16;
   localparam int INSTRUCTION_WIDTH = 4 + 2*OPERAND_WIDTH_DEF;
   localparam int RESULT_WIDTH      = 2*OPERAND_WIDTH_DEF;

   localparam int OPCODE_LSB    = 0;
   localparam int OPCODE_WIDTH  = 4;
   localparam int OPERAND_A_LSB = 4;

   // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_ADD    = 4'd1,
      OP_SUB    = 4'd2,
      OP_MUL    = 4'd3,
      OP_MAX    = 4'd4,
      OP_RELU   = 4'd5,
      OP_RAND   = 4'd6,
      OP_MAC    = 4'd7,
      OP_CLRACC = 4'd8
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MULT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/datapath_unit_seq_multiplier.sv
// seq_multiplier: radix-2 signed shift-add multiplier, WIDTH iterations.
// The last iteration subtracts the shifted multiplicand, which handles the
// negative weight of the multiplier's sign bit.
module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] addend;
   logic [WIDTH-1:0]   mplr_q;
   logic [CW-1:0]      cnt_q;
   logic               last;

   assign last    = (cnt_q == CW'(1));
   assign done    = last;
   assign product = acc_q;

   // partial product for the current multiplier bit, negated on the sign bit
   always_comb begin
      addend = '0;
      if (mplr_q[0]) begin
         addend = last ? (~mcand_q + 1'b1) : mcand_q;
      end
   end

   // load on start, then one shift-add step per cycle until the count expires
   always_ff @(posedge clock) begin
      if (!resetn) begin
         mcand_q <= '0;
         acc_q   <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else if (start) begin
         mcand_q <= {{WIDTH{a[WIDTH-1]}}, a};
         acc_q   <= '0;
         mplr_q  <= b;
         cnt_q   <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
         acc_q   <= acc_q + addend;
         mcand_q <= mcand_q << 1;
         mplr_q  <= mplr_q >> 1;
         cnt_q   <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: executes one instruction per start_dp rising edge and
// returns result_dp with a one-cycle finished_dp pulse.
// Optional feature macro: DATAPATH_UNIT_MUL_EN (multiplier, MUL/MAC/CLRACC).
//
// state | meaning
// IDLE  | waiting for a new start_dp rising edge
// EXEC  | decode; single-cycle ops computed, MUL/MAC load the multiplier
// MULT  | sequential multiply running
// DONE  | publish result, pulse finished_dp on the following cycle
module datapath_unit
   import datapath_unit_pkg::*;
#(
   parameter int          OPERAND_WIDTH = OPERAND_WIDTH_DEF,
   parameter logic [31:0] LFSR_SEED     = 32'h0000_0001
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
   input  logic                         start_dp,
   output logic [RESULT_WIDTH-1:0]      result_dp,
   output logic                         finished_dp,
   output logic                         busy,
   output logic                         illegal
);

   localparam int RW    = RESULT_WIDTH;
   localparam int OW    = OPERAND_WIDTH;
   localparam int B_LSB = OPERAND_A_LSB + OW;

   state_e          state_q, state_d;
   logic            start_q;
   logic            accept;
   logic [3:0]      op_q;
   logic [OW-1:0]   a_q, b_q;
   logic [RW-1:0]   a_ext, b_ext;
   logic [RW-1:0]   res_q, exec_res, done_res;
   logic            ill_q, exec_ill;
   logic [31:0]     lfsr_q;
   logic            mul_start;

   assign accept = (state_q == ST_IDLE) && start_dp && !start_q;
   assign a_ext  = {{(RW-OW){a_q[OW-1]}}, a_q};
   assign b_ext  = {{(RW-OW){b_q[OW-1]}}, b_q};

`ifdef DATAPATH_UNIT_MUL_EN
   logic [2*OW-1:0] product;
   logic [RW-1:0]   p_ext;
   logic [RW-1:0]   acc_q;
   logic [RW-1:0]   mac_sum;
   logic            mul_done;

   seq_multiplier #(.WIDTH(OW)) u_mul (
      .clock   (clock),
      .resetn  (resetn),
      .start   (mul_start),
      .a       (a_q),
      .b       (b_q),
      .product (product),
      .done    (mul_done)
   );

   assign p_ext   = {{(RW-2*OW){product[2*OW-1]}}, product};
   assign mac_sum = acc_q + p_ext;
`endif

   // state register
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic and multiplier launch
   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_DONE;
`ifdef DATAPATH_UNIT_MUL_EN
            if (op_q == OP_MUL || op_q == OP_MAC) begin
               state_d   = ST_MULT;
               mul_start = 1'b1;
            end
`endif
         end
`ifdef DATAPATH_UNIT_MUL_EN
         ST_MULT: if (mul_done) state_d = ST_DONE;
`else
         ST_MULT: state_d = ST_IDLE;
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // single-cycle operation decode
   always_comb begin
      exec_res = '0;
      exec_ill = 1'b0;
      case (op_q)
         OP_NOP:  exec_res = '0;
         OP_ADD:  exec_res = a_ext + b_ext;
         OP_SUB:  exec_res = a_ext - b_ext;
         OP_MAX:  exec_res = ($signed(a_q) > $signed(b_q)) ? a_ext : b_ext;
         OP_RELU: exec_res = a_q[OW-1] ? '0 : a_ext;
         OP_RAND: exec_res = RW'(lfsr_q);
`ifdef DATAPATH_UNIT_MUL_EN
         OP_MUL, OP_MAC, OP_CLRACC: exec_res = '0;
`endif
         default: begin
            exec_res = '1;
            exec_ill = 1'b1;
         end
      endcase
   end

   // value published in DONE: multiplier-based ops bypass the EXEC result
   always_comb begin
      done_res = res_q;
`ifdef DATAPATH_UNIT_MUL_EN
      if (op_q == OP_MUL) done_res = p_ext;
      if (op_q == OP_MAC) done_res = mac_sum;
`endif
   end

   // operand capture, architectural state and registered outputs
   always_ff @(posedge clock) begin
      if (!resetn) begin
         start_q     <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         ill_q       <= 1'b0;
         lfsr_q      <= LFSR_SEED;
         result_dp   <= '0;
         finished_dp <= 1'b0;
         busy        <= 1'b0;
         illegal     <= 1'b0;
`ifdef DATAPATH_UNIT_MUL_EN
         acc_q       <= '0;
`endif
      end else begin
         start_q     <= start_dp;
         finished_dp <= 1'b0;
         illegal     <= 1'b0;
         busy        <= (state_d != ST_IDLE) || (state_q == ST_DONE);
         if (accept) begin
            op_q <= instruction_dp[OPCODE_LSB +: OPCODE_WIDTH];
            a_q  <= instruction_dp[OPERAND_A_LSB +: OW];
            b_q  <= instruction_dp[B_LSB +: OW];
         end
         if (state_q == ST_EXEC) begin
            res_q <= exec_res;
            ill_q <= exec_ill;
            if (op_q == OP_RAND) lfsr_q <= lfsr_step(lfsr_q);
`ifdef DATAPATH_UNIT_MUL_EN
            if (op_q == OP_CLRACC) acc_q <= '0;
`endif
         end
         if (state_q == ST_DONE) begin
            finished_dp <= 1'b1;
            illegal     <= ill_q;
            result_dp   <= done_res;
`ifdef DATAPATH_UNIT_MUL_EN
            if (op_q == OP_MAC) acc_q <= mac_sum;
`endif
         end
      end
   end

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: vector table plus multi-cycle sequences.
// Multiplier vectors are included only when DATAPATH_UNIT_MUL_EN is defined.
module tb_datapath_unit;

   logic        clock = 1'b0;
   logic        resetn;
   logic [35:0] instruction_dp;
   logic        start_dp;
   logic [31:0] result_dp;
   logic        finished_dp;
   logic        busy;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   localparam int SC_LAT  = 3;
   localparam int MUL_LAT = 3 + 16;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] res;
      logic        ill;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   datapath_unit dut (
      .clock          (clock),
      .resetn         (resetn),
      .instruction_dp (instruction_dp),
      .start_dp       (start_dp),
      .result_dp      (result_dp),
      .finished_dp    (finished_dp),
      .busy           (busy),
      .illegal        (illegal)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic set_instr(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      instruction_dp        = '0;
      instruction_dp[3:0]   = op;
      instruction_dp[19:4]  = a;
      instruction_dp[35:20] = b;
   endtask

   // router-style transaction: start held two cycles, wait bounded for the pulse
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_res, input logic exp_ill, input int exp_lat,
                         input string name);
      int lat;
      logic busy_ok;
      lat = 0;
      busy_ok = 1'b1;
      set_instr(op, a, b);
      start_dp = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         if (k == 2) start_dp = 1'b0;
         if (finished_dp) begin
            lat = k;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      start_dp = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_result"}, 64'(result_dp), 64'(exp_res));
      check({name, "_illegal"}, 64'(illegal), 64'(exp_ill));
      check({name, "_busy_run"}, 64'(busy_ok & busy), 64'd1);
      @(negedge clock);
      check({name, "_pulse_end"}, 64'(finished_dp), 64'd0);
      check({name, "_busy_end"}, 64'(busy), 64'd0);
      check({name, "_result_hold"}, 64'(result_dp), 64'(exp_res));
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] res, input logic ill, input int lat, input string name);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      int fin;
      logic [31:0] r;
      int fin_k;

      add_vec(4'd1, 16'd5,     16'hFFF9, 32'hFFFF_FFFE, 1'b0, SC_LAT, "add_5_m7");
      add_vec(4'd1, 16'h7FFF,  16'h7FFF, 32'h0000_FFFE, 1'b0, SC_LAT, "add_max");
      add_vec(4'd2, 16'h8000,  16'd1,    32'hFFFF_7FFF, 1'b0, SC_LAT, "sub_min_1");
      add_vec(4'd2, 16'd100,   16'd300,  32'hFFFF_FF38, 1'b0, SC_LAT, "sub_neg");
      add_vec(4'd4, 16'hFFFB,  16'hFFF7, 32'hFFFF_FFFB, 1'b0, SC_LAT, "max_negs");
      add_vec(4'd4, 16'd3,     16'hFFFF, 32'h0000_0003, 1'b0, SC_LAT, "max_mixed");
      add_vec(4'd4, 16'h8000,  16'h7FFF, 32'h0000_7FFF, 1'b0, SC_LAT, "max_signed");
      add_vec(4'd5, 16'hFFFF,  16'd9,    32'h0000_0000, 1'b0, SC_LAT, "relu_neg");
      add_vec(4'd5, 16'h1234,  16'd0,    32'h0000_1234, 1'b0, SC_LAT, "relu_pos");
      add_vec(4'd5, 16'h0000,  16'd0,    32'h0000_0000, 1'b0, SC_LAT, "relu_zero");
      add_vec(4'd0, 16'd5,     16'd6,    32'h0000_0000, 1'b0, SC_LAT, "nop");
      add_vec(4'd12, 16'd1,    16'd2,    32'hFFFF_FFFF, 1'b1, SC_LAT, "op12");
      add_vec(4'd15, 16'd0,    16'd0,    32'hFFFF_FFFF, 1'b1, SC_LAT, "op15");
`ifdef DATAPATH_UNIT_MUL_EN
      add_vec(4'd3, 16'hFFFD,  16'd1000, 32'hFFFF_F448, 1'b0, MUL_LAT, "mul_m3_1000");
      add_vec(4'd3, 16'd7,     16'hFFFE, 32'hFFFF_FFF2, 1'b0, MUL_LAT, "mul_7_m2");
      add_vec(4'd3, 16'h8000,  16'h8000, 32'h4000_0000, 1'b0, MUL_LAT, "mul_min_min");
      add_vec(4'd3, 16'h7FFF,  16'h7FFF, 32'h3FFF_0001, 1'b0, MUL_LAT, "mul_max_max");
      add_vec(4'd8, 16'd0,     16'd0,    32'h0000_0000, 1'b0, SC_LAT,  "clracc_a");
      add_vec(4'd7, 16'd2,     16'd3,    32'h0000_0006, 1'b0, MUL_LAT, "mac_2_3");
      add_vec(4'd7, 16'd4,     16'd5,    32'h0000_001A, 1'b0, MUL_LAT, "mac_4_5");
      add_vec(4'd8, 16'd0,     16'd0,    32'h0000_0000, 1'b0, SC_LAT,  "clracc_b");
      add_vec(4'd7, 16'h8000,  16'h8000, 32'h4000_0000, 1'b0, MUL_LAT, "mac_big1");
      add_vec(4'd7, 16'h8000,  16'h8000, 32'h8000_0000, 1'b0, MUL_LAT, "mac_wrap");
`else
      add_vec(4'd3, 16'hFFFD,  16'd1000, 32'hFFFF_FFFF, 1'b1, SC_LAT, "mul_absent");
      add_vec(4'd7, 16'd2,     16'd3,    32'hFFFF_FFFF, 1'b1, SC_LAT, "mac_absent");
      add_vec(4'd8, 16'd0,     16'd0,    32'hFFFF_FFFF, 1'b1, SC_LAT, "clracc_absent");
`endif

      resetn   = 1'b0;
      start_dp = 1'b0;
      instruction_dp = '0;
      repeat (3) @(negedge clock);
      check("rst_result", 64'(result_dp), 64'd0);
      check("rst_finished", 64'(finished_dp), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      resetn = 1'b1;
      @(negedge clock);

      // LFSR starts at the seed and only advances on RAND
      run_op(4'd6, 16'd0, 16'd0, 32'h0000_0001, 1'b0, SC_LAT, "rand_first");
      run_op(4'd1, 16'd1, 16'd1, 32'h0000_0002, 1'b0, SC_LAT, "add_between");
      run_op(4'd6, 16'd0, 16'd0, 32'h8020_0003, 1'b0, SC_LAT, "rand_second");
      run_op(4'd6, 16'd0, 16'd0, 32'hC030_0002, 1'b0, SC_LAT, "rand_third");

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, vecs[i].lat, vecs[i].name);
      end

      // start held high for five cycles: one completion only
      set_instr(4'd1, 16'd1, 16'd2);
      start_dp = 1'b1;
      fin = 0;
      r = '0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         if (k == 5) start_dp = 1'b0;
         if (finished_dp) begin
            fin++;
            r = result_dp;
         end
      end
      check("held_finishes", 64'(fin), 64'd1);
      check("held_result", 64'(r), 64'd3);

      // rising edge landing in the DONE cycle is ignored
      set_instr(4'd1, 16'd10, 16'd20);
      start_dp = 1'b1;
      fin = 0;
      fin_k = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         if (k == 1) start_dp = 1'b0;
         if (k == 2) start_dp = 1'b1;
         if (k == 6) start_dp = 1'b0;
         if (finished_dp) begin
            fin++;
            fin_k = k;
         end
      end
      check("done_edge_finishes", 64'(fin), 64'd1);
      check("done_edge_latency", 64'(fin_k), 64'd3);
      check("done_edge_result", 64'(result_dp), 64'd30);

`ifdef DATAPATH_UNIT_MUL_EN
      // second edge mid-MULT is dropped
      set_instr(4'd3, 16'd9, 16'hFFFC);
      start_dp = 1'b1;
      fin = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 2) start_dp = 1'b0;
         if (k == 8) begin
            set_instr(4'd1, 16'd1, 16'd1);
            start_dp = 1'b1;
         end
         if (k == 10) start_dp = 1'b0;
         if (finished_dp) fin++;
      end
      check("mid_mult_finishes", 64'(fin), 64'd1);
      check("mid_mult_result", 64'(result_dp), 64'hFFFF_FFDC);
      set_instr(4'd3, 16'd100, 16'd100);
      fin_k = 6;
`else
      set_instr(4'd1, 16'd100, 16'd100);
      fin_k = 1;
`endif

      // reset while an operation is in flight
      start_dp = 1'b1;
      for (int k = 1; k <= fin_k; k++) begin
         @(negedge clock);
         if (k == 2) start_dp = 1'b0;
      end
      resetn   = 1'b0;
      start_dp = 1'b0;
      @(negedge clock);
      check("midrst_result", 64'(result_dp), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_finished", 64'(finished_dp), 64'd0);
      check("midrst_illegal", 64'(illegal), 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      fin = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clock);
         if (finished_dp) fin++;
      end
      check("midrst_no_finish", 64'(fin), 64'd0);
      check("midrst_result_after", 64'(result_dp), 64'd0);

      run_op(4'd6, 16'd0, 16'd0, 32'h0000_0001, 1'b0, SC_LAT, "rand_after_rst");
      run_op(4'd1, 16'd5, 16'hFFF9, 32'hFFFF_FFFE, 1'b0, SC_LAT, "add_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Execution engine on the datapath side of the shared instruction handshake: accepts one instruction per `start_dp` rising edge from the datapath router, executes it (single-cycle arithmetic, LFSR random, optional multi-cycle multiply / multiply-accumulate) and returns `result_dp` with a one-cycle `finished_dp` pulse. It sits directly below the router, so every thread's neuron arithmetic funnels through one instance.

## Interface
- `OPERAND_WIDTH`, 16, signed operand width; requires `RESULT_WIDTH` >= 2*`OPERAND_WIDTH` and `INSTRUCTION_WIDTH` >= 4+2*`OPERAND_WIDTH`
- `LFSR_SEED`, 32'h0000_0001, LFSR reset value; must be nonzero
- `clock` in 1: single clock, all logic on posedge
- `resetn` in 1: synchronous, active-low reset
- `instruction_dp` in `INSTRUCTION_WIDTH`: [3:0] opcode, [4 +: OPERAND_WIDTH] operand A, [4+OPERAND_WIDTH +: OPERAND_WIDTH] operand B; upper bits ignored
- `start_dp` in 1: request; accepted on rising edge only
- `result_dp` out `RESULT_WIDTH`: result of last completed instruction, held until next completion
- `finished_dp` out 1: one-cycle completion pulse
- `busy` out 1: high from accept to completion pulse inclusive
- `illegal` out 1: pulses with `finished_dp` when opcode is unsupported

## Operation
- States: IDLE, EXEC, MULT, DONE.
- IDLE: on `start_dp & ~start_q` (registered previous `start_dp`), latch opcode/A/B, go EXEC. Level-high `start_dp` without new edge never re-triggers.
- EXEC: decode. Single-cycle ops compute into result register, go DONE. MUL/MAC load multiplier, go MULT.
- Opcodes: 0 NOP -> 0; 1 ADD -> sext(A)+sext(B); 2 SUB -> sext(A)-sext(B); 3 MUL -> A*B signed; 4 MAX -> signed max, sign-extended; 5 RELU -> A<0 ? 0 : A; 6 RAND -> current 32-bit LFSR state (zero-extended/truncated to `RESULT_WIDTH`), LFSR then advances one step; 7 MAC -> acc <= acc + A*B, result = new acc; 8 CLRACC -> acc <= 0, result 0; 9-15 illegal -> result all ones, `illegal` pulses.
- Arithmetic: all results sign-extended to `RESULT_WIDTH`; accumulator `RESULT_WIDTH` bits, wraps modulo 2^`RESULT_WIDTH`, no saturation.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1, advances only on RAND.
- MULT: radix-2 signed shift-add (Baugh-Wooley or sign-corrected), exactly `OPERAND_WIDTH` iterations, then DONE.
- DONE: drive `finished_dp`=1 for this cycle only, update `result_dp`, return to IDLE.
- `start_dp` edges while not IDLE are ignored (no queueing); `start_q` still tracks so a held level is not seen as new edge on return to IDLE.

## Timing
- Reset values: `result_dp`=0, `finished_dp`=0, `busy`=0, `illegal`=0, state IDLE, acc=0, LFSR=`LFSR_SEED`, `start_q`=0.
- Edge sampled at clock edge E: `finished_dp` high in cycle after edge E+2 for single-cycle ops; after edge E+2+`OPERAND_WIDTH` for MUL/MAC.
- `result_dp` valid with `finished_dp` and stable until next DONE.
- Router holds `start_dp` two cycles and samples `finished_dp` every cycle while waiting; single-cycle pulse is sufficient.
- Reset mid-operation: abort, all state to reset values next edge, no `finished_dp`.
- `start_dp` rising in the DONE cycle: ignored.

## Configuration
- `DATAPATH_UNIT_MUL_EN`: defined -> MULT state, multiplier and accumulator present, opcodes 3 and 7 as above. Undefined -> no multiplier/accumulator hardware; opcodes 3, 7, 8 treated as illegal (all-ones result, `illegal` pulse, single-cycle latency).

## Structure
- Shared package / `constants.h`: `INSTRUCTION_WIDTH`, `RESULT_WIDTH`, opcode constants `OP_NOP`..`OP_CLRACC`, field offsets, LFSR polynomial.
- One sub-module: `seq_multiplier` (start/done, signed `OPERAND_WIDTH` x `OPERAND_WIDTH` -> 2*`OPERAND_WIDTH`), only instantiated under `DATAPATH_UNIT_MUL_EN`.

## Test plan
- Reset, ADD A=5 B=-7 -> `result_dp`=-2 sign-extended, `finished_dp` one cycle, 2 cycles after accepting edge.
- MUL A=-3 B=1000 (MUL_EN) -> -3000 after 2+16 cycles; `busy` high throughout.
- CLRACC, MAC (2,3), MAC (4,5) -> results 0, 6, 26; MAC with acc near max wraps to negative.
- RAND twice after reset with seed 1 -> first result 1, second the one-step Galois successor; LFSR unchanged by other ops.
- `start_dp` held high 5 cycles, and a second edge mid-MULT -> exactly one `finished_dp`; opcode 12 -> all-ones, `illegal` pulse.
- `resetn` low during MULT -> no `finished_dp`, outputs 0; new ADD after release completes normally.
